// File: rtl/bloco_controle.sv
// Moore sequencer for the 16-bit X/H/S datapath: CLR, SUM3, DSUM and ACC macro-operations.
// Optional macro CTRL_STEP_EN adds a 'step' input that gates every non-IDLE transition.
module bloco_controle #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] n,
`ifdef CTRL_STEP_EN
  input  logic             step,
`endif
  output logic             lx,
  output logic             lh,
  output logic             ls,
  output logic [1:0]       m0,
  output logic [1:0]       m1,
  output logic [1:0]       m2,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S_CLR  = 4'd1,
    LDX    = 4'd2,
    LDH    = 4'd3,
    ADDXH  = 4'd4,
    ADDC   = 4'd5,
    DBL    = 4'd6,
    ACC_LD = 4'd7,
    ACCS   = 4'd8,
    DONE   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_SUM3 = 2'b01,
    OP_DSUM = 2'b10,
    OP_ACC  = 2'b11
  } op_t;

  typedef struct packed {
    logic       lx;
    logic       lh;
    logic       ls;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       busy;
    logic       done;
  } ctrl_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  ctrl_t            ctrl_q;
  logic             adv;

`ifdef CTRL_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Output pattern for a state; unknown encodings decode to all zeros like IDLE.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_CLR:  begin c.ls = 1'b1;                                           c.busy = 1'b1; end
      LDX:    begin c.lx = 1'b1; c.m0 = 2'b01;                              c.busy = 1'b1; end
      LDH:    begin c.lh = 1'b1; c.m0 = 2'b10;                              c.busy = 1'b1; end
      ADDXH:  begin c.ls = 1'b1; c.m1 = 2'b01; c.m2 = 2'b10;                c.busy = 1'b1; end
      ADDC:   begin c.ls = 1'b1; c.m0 = 2'b11; c.m1 = 2'b00; c.m2 = 2'b11;  c.busy = 1'b1; end
      DBL:    begin c.ls = 1'b1; c.m1 = 2'b10; c.m2 = 2'b11;                c.busy = 1'b1; end
      ACC_LD: begin                                                        c.busy = 1'b1; end
      ACCS:   begin c.ls = 1'b1; c.m0 = 2'b01; c.m1 = 2'b10; c.m2 = 2'b00;  c.busy = 1'b1; end
      DONE:   begin c.busy = 1'b1; c.done = 1'b1;                                         end
      default: c = '0;
    endcase
    return c;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          case (op_t'(op))
            OP_CLR:  state_nxt = S_CLR;
            OP_ACC:  state_nxt = ACC_LD;
            default: state_nxt = LDX;
          endcase
        end
      end
      S_CLR:  if (adv) state_nxt = DONE;
      LDX:    if (adv) state_nxt = LDH;
      LDH:    if (adv) state_nxt = ADDXH;
      ADDXH:  if (adv) state_nxt = (op_q == OP_SUM3) ? ADDC : DBL;
      ADDC:   if (adv) state_nxt = DONE;
      DBL:    if (adv) state_nxt = DONE;
      ACC_LD: begin
        if (adv) begin
          cnt_nxt   = n_q;
          state_nxt = (n_q == '0) ? DONE : ACCS;
        end
      end
      ACCS: begin
        if (adv) begin
          // Saturating decrement: the last ACCS cycle leaves the counter at zero.
          if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
          state_nxt = (cnt <= CNT_W'(1)) ? DONE : ACCS;
        end
      end
      DONE:   if (adv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_CLR;
      n_q    <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      // Outputs are registered from the next state so they line up with the state they describe.
      ctrl_q <= decode(state_nxt);
      if (state == IDLE && start) begin
        op_q <= op_t'(op);
        n_q  <= n;
      end
    end
  end

  assign lx   = ctrl_q.lx;
  assign lh   = ctrl_q.lh;
  assign ls   = ctrl_q.ls;
  assign m0   = ctrl_q.m0;
  assign m1   = ctrl_q.m1;
  assign m2   = ctrl_q.m2;
  assign busy = ctrl_q.busy;
  assign done = ctrl_q.done;

endmodule
